// File: rtl/rs_age_issue.sv
// Age-ordered reservation station: buffers dispatched ALU ops, snoops NCDB result buses, and issues the oldest ready entry.
// Optional build macro RS_STATS_EN adds free-running issue and full-stall counters.
module rs_age_issue #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int NCDB   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy_i,
    input  logic                         clr_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [OP_W-1:0]              alloc_op_i,
    input  logic [DATA_W-1:0]            alloc_imm_i,
    input  logic [DATA_W-1:0]            alloc_pc_i,
    input  logic [TAG_W-1:0]             alloc_tag_i,
    input  logic                         alloc_qj_i,
    input  logic [DATA_W-1:0]            alloc_vj_i,
    input  logic                         alloc_qk_i,
    input  logic [DATA_W-1:0]            alloc_vk_i,
    input  logic [NCDB-1:0]              cdb_valid_i,
    input  logic [NCDB*TAG_W-1:0]        cdb_tag_i,
    input  logic [NCDB*DATA_W-1:0]       cdb_value_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output logic [OP_W-1:0]              issue_op_o,
    output logic [DATA_W-1:0]            issue_vj_o,
    output logic [DATA_W-1:0]            issue_vk_o,
    output logic [DATA_W-1:0]            issue_imm_o,
    output logic [DATA_W-1:0]            issue_pc_o,
    output logic [TAG_W-1:0]             issue_tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef RS_STATS_EN
    ,
    output logic [31:0]                  stat_issued_o,
    output logic [31:0]                  stat_full_o
`endif
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d, qj_q, qj_d, qk_q, qk_d;
    logic [DATA_W-1:0] vj_q [DEPTH];
    logic [DATA_W-1:0] vj_d [DEPTH];
    logic [DATA_W-1:0] vk_q [DEPTH];
    logic [DATA_W-1:0] vk_d [DEPTH];
    logic [OP_W-1:0]   op_q [DEPTH];
    logic [DATA_W-1:0] imm_q [DEPTH];
    logic [DATA_W-1:0] pc_q [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    // older_q[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [DEPTH-1:0]  older_d [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic              issue_valid_q, issue_valid_d;
    logic [DEPTH-1:0]  ready_vec;
    logic              any_ready, blocked;
    logic [IDX_W-1:0]  sel_idx, free_idx;
    logic              alloc_fire, move_en, issue_move;
    logic [DATA_W:0]   snp_j, snp_k;

    // Returns {pending, value}; lowest channel wins when several match.
    function automatic logic [DATA_W:0] snoop(input logic pend, input logic [DATA_W-1:0] v);
        logic [DATA_W:0] r;
        r = {pend, v};
        if (pend) begin
            for (int c = NCDB-1; c >= 0; c--) begin
                if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == v[TAG_W-1:0]))
                    r = {1'b0, cdb_value_i[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    assign alloc_ready_o = (count_q < CNT_W'(DEPTH));
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign move_en       = !issue_valid_q || issue_ready_i;
    assign issue_move    = move_en && any_ready;
    assign count_o       = count_q;
    assign issue_valid_o = issue_valid_q;

    always_comb begin
        ready_vec = valid_q & ~qj_q & ~qk_q;
        any_ready = |ready_vec;
        sel_idx   = '0;
        blocked   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_vec[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (ready_vec[i] && !blocked) sel_idx = IDX_W'(i);
        end
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        older_d = older_q;
        snp_j   = '0;
        snp_k   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            snp_j   = snoop(qj_q[i], vj_q[i]);
            snp_k   = snoop(qk_q[i], vk_q[i]);
            qj_d[i] = snp_j[DATA_W];
            vj_d[i] = snp_j[DATA_W-1:0];
            qk_d[i] = snp_k[DATA_W];
            vk_d[i] = snp_k[DATA_W-1:0];
        end
        if (issue_move) valid_d[sel_idx] = 1'b0;
        if (alloc_fire) begin
            snp_j             = snoop(alloc_qj_i, alloc_vj_i);
            snp_k             = snoop(alloc_qk_i, alloc_vk_i);
            valid_d[free_idx] = 1'b1;
            qj_d[free_idx]    = snp_j[DATA_W];
            vj_d[free_idx]    = snp_j[DATA_W-1:0];
            qk_d[free_idx]    = snp_k[DATA_W];
            vk_d[free_idx]    = snp_k[DATA_W-1:0];
            for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b1;
            older_d[free_idx] = '0;
        end
        count_d       = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_move);
        issue_valid_d = move_en ? any_ready : issue_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q       <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
        end else if (rdy_i) begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy_i) begin
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            older_q <= older_d;
            if (alloc_fire) begin
                op_q[free_idx]  <= alloc_op_i;
                imm_q[free_idx] <= alloc_imm_i;
                pc_q[free_idx]  <= alloc_pc_i;
                tag_q[free_idx] <= alloc_tag_i;
            end
            if (issue_move) begin
                issue_op_o  <= op_q[sel_idx];
                issue_vj_o  <= vj_q[sel_idx];
                issue_vk_o  <= vk_q[sel_idx];
                issue_imm_o <= imm_q[sel_idx];
                issue_pc_o  <= pc_q[sel_idx];
                issue_tag_o <= tag_q[sel_idx];
            end
        end
    end

`ifdef RS_STATS_EN
    logic [31:0] stat_issued_q, stat_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_full_q   <= '0;
        end else if (rdy_i) begin
            if (issue_valid_q && issue_ready_i) stat_issued_q <= stat_issued_q + 32'd1;
            if (alloc_valid_i && !alloc_ready_o) stat_full_q <= stat_full_q + 32'd1;
        end
    end

    assign stat_issued_o = stat_issued_q;
    assign stat_full_o   = stat_full_q;
`endif

endmodule
